// File: rtl/imu_uart_packetizer.sv
// Frames one multi-channel IMU sample as SYNC0 SYNC1 seq data... CHK and
// feeds it byte by byte to a UART transmitter over tx_start/tx_data/tx_busy.
module imu_uart_packetizer #(
  parameter int unsigned NUM_CH = 3,
  parameter logic [7:0]  SYNC0  = 8'hA5,
  parameter logic [7:0]  SYNC1  = 8'h5A
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_valid,
  input  logic [16*NUM_CH-1:0]  sample_data,
  output logic                  sample_ready,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_busy,
  output logic                  pkt_busy,
  output logic [7:0]            seq,
  output logic [7:0]            drop_cnt
);

  localparam int unsigned PKT_LEN  = 4 + 2 * NUM_CH;
  localparam logic [4:0]  LAST_IDX = 5'(PKT_LEN - 1);
  localparam int unsigned BSEL_W   = $clog2(2 * NUM_CH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LOAD    = 2'd1;
  localparam logic [1:0] S_WAIT_HI = 2'd2;
  localparam logic [1:0] S_WAIT_LO = 2'd3;

  logic [1:0]           state;
  logic [4:0]           idx;
  logic [16*NUM_CH-1:0] sample_q;
  logic [7:0]           chk_sum;
  logic [7:0]           data_bytes [2*NUM_CH];
  logic [4:0]           data_idx;
  logic [7:0]           cur_byte;
  logic                 handshake;
  logic                 in_sum;

  assign handshake = sample_valid & sample_ready;
  assign data_idx  = idx - 5'd3;
  assign in_sum    = (idx >= 5'd2) && (idx < LAST_IDX);

  // Channel k contributes its MSB then its LSB.
  always_comb begin
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      data_bytes[2*k]   = sample_q[16*k+8 +: 8];
      data_bytes[2*k+1] = sample_q[16*k   +: 8];
    end
  end

  always_comb begin
    cur_byte = '0;
    if (idx == 5'd0)          cur_byte = SYNC0;
    else if (idx == 5'd1)     cur_byte = SYNC1;
    else if (idx == 5'd2)     cur_byte = seq;
    else if (idx == LAST_IDX) cur_byte = chk_sum;
    else                      cur_byte = data_bytes[data_idx[BSEL_W-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      idx          <= '0;
      sample_q     <= '0;
      chk_sum      <= '0;
      sample_ready <= 1'b0;
      tx_start     <= 1'b0;
      tx_data      <= '0;
      pkt_busy     <= 1'b0;
      seq          <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (handshake) begin
            sample_q     <= sample_data;
            idx          <= '0;
            chk_sum      <= '0;
            pkt_busy     <= 1'b1;
            sample_ready <= 1'b0;
            state        <= S_LOAD;
          end else begin
            sample_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          if (!tx_busy) begin
            tx_data  <= cur_byte;
            tx_start <= 1'b1;
            if (in_sum) chk_sum <= chk_sum + cur_byte;
            state    <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (tx_busy) state <= S_WAIT_LO;
        end
        S_WAIT_LO: begin
          if (!tx_busy) begin
            if (idx < LAST_IDX) begin
              idx   <= idx + 5'd1;
              state <= S_LOAD;
            end else begin
              seq          <= seq + 8'd1;
              pkt_busy     <= 1'b0;
              sample_ready <= 1'b1;
              state        <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (sample_valid && !sample_ready && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_imu_uart_packetizer.sv
// Directed bench for imu_uart_packetizer with a behavioural transmitter model.
module tb_imu_uart_packetizer;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [47:0] sample_data = '0;
  logic        sample_ready, tx_start, tx_busy, pkt_busy;
  logic [7:0]  tx_data, seq, drop_cnt;

  logic        sample_valid1 = 1'b0;
  logic [15:0] sample_data1 = '0;
  logic        sample_ready1, tx_start1, tx_busy1, pkt_busy1;
  logic [7:0]  tx_data1, seq1, drop_cnt1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imu_uart_packetizer #(.NUM_CH(3), .SYNC0(8'hA5), .SYNC1(8'h5A)) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_data(sample_data),
    .sample_ready(sample_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .pkt_busy(pkt_busy), .seq(seq), .drop_cnt(drop_cnt)
  );

  imu_uart_packetizer #(.NUM_CH(1), .SYNC0(8'hA5), .SYNC1(8'h5A)) dut1 (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid1), .sample_data(sample_data1),
    .sample_ready(sample_ready1), .tx_start(tx_start1), .tx_data(tx_data1), .tx_busy(tx_busy1),
    .pkt_busy(pkt_busy1), .seq(seq1), .drop_cnt(drop_cnt1)
  );

  // Transmitter model: busy rises the cycle after tx_start, stays up busy_len cycles.
  logic        busy_q = 1'b0;
  logic        glitch = 1'b0;
  int unsigned busy_cnt = 0;
  int unsigned busy_len = 3;
  assign tx_busy = busy_q | glitch;

  always @(posedge clk) begin
    if (tx_start) begin
      busy_q   <= 1'b1;
      busy_cnt <= busy_len;
    end else if (busy_q) begin
      if (busy_cnt <= 1) busy_q <= 1'b0;
      else busy_cnt <= busy_cnt - 1;
    end
  end

  logic        busy1_q = 1'b0;
  int unsigned busy1_cnt = 0;
  assign tx_busy1 = busy1_q;

  always @(posedge clk) begin
    if (tx_start1) begin
      busy1_q   <= 1'b1;
      busy1_cnt <= 2;
    end else if (busy1_q) begin
      if (busy1_cnt <= 1) busy1_q <= 1'b0;
      else busy1_cnt <= busy1_cnt - 1;
    end
  end

  // Byte capture and protocol monitors.
  bq_t        q, q1;
  int         starts = 0;
  int         overlap_viol = 0, width_viol = 0, stable_viol = 0;
  logic       prev_start = 1'b0;
  logic [7:0] last_byte = '0;

  always @(negedge clk) begin
    if (tx_start) begin
      q.push_back(tx_data);
      starts++;
      if (tx_busy) overlap_viol++;
      if (prev_start) width_viol++;
      last_byte = tx_data;
    end
    if (tx_busy && (tx_data != last_byte)) stable_viol++;
    prev_start = tx_start;
    if (tx_start1) q1.push_back(tx_data1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_pkt(input string tag, input bq_t got, input bq_t exp);
    logic [7:0] g;
    check({tag, "_len"}, got.size(), exp.size());
    foreach (exp[i]) begin
      g = (i < got.size()) ? got[i] : 8'h00;
      check($sformatf("%s_b%0d", tag, i), g, exp[i]);
    end
  endtask

  task automatic send_sample(input logic [47:0] d);
    int n;
    n = 0;
    @(negedge clk);
    sample_data  = d;
    sample_valid = 1'b1;
    while (!sample_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("accept_timeout", 0, 1);
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (pkt_busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (pkt_busy) check("done_timeout", 1, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int s0, n, done_at;
    logic seen_done, ready_at_done, restarted;
    bq_t pkt1;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ready", sample_ready, 0);
    check("rst_start", tx_start, 0);
    check("rst_data", tx_data, 8'h00);
    check("rst_pkt_busy", pkt_busy, 0);
    check("rst_seq", seq, 0);
    check("rst_drop", drop_cnt, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready", sample_ready, 1);

    // Basic packet
    busy_len = 3;
    q.delete();
    s0 = starts;
    send_sample({16'h0001, 16'hABCD, 16'h1234});
    wait_done(5000);
    check_pkt("t1", q, '{8'hA5, 8'h5A, 8'h00, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hBF});
    check("t1_starts", starts - s0, 10);
    check("t1_seq", seq, 1);

    // Long then short busy; protocol monitors
    overlap_viol = 0; width_viol = 0; stable_viol = 0;
    busy_len = 8680;
    q.delete();
    s0 = starts;
    send_sample({16'hFFFF, 16'h8080, 16'h0102});
    n = 0;
    while ((starts - s0 < 2) && n < 20000) begin @(negedge clk); n++; end
    n = 0;
    while (!tx_busy && n < 10) begin @(negedge clk); n++; end
    busy_len = 3;
    wait_done(20000);
    check_pkt("t2", q, '{8'hA5, 8'h5A, 8'h01, 8'h01, 8'h02, 8'h80, 8'h80, 8'hFF, 8'hFF, 8'h02});
    check("t2_overlap", overlap_viol, 0);
    check("t2_width", width_viol, 0);
    check("t2_stable", stable_viol, 0);

    // Busy glitch while in LOAD stalls the first byte
    glitch = 1'b1;
    q.delete();
    s0 = starts;
    send_sample('0);
    repeat (5) @(negedge clk);
    check("glitch_no_start", starts - s0, 0);
    check("glitch_pkt_busy", pkt_busy, 1);
    glitch = 1'b0;
    wait_done(5000);
    check("glitch_len", q.size(), 10);
    check("glitch_chk", q[9], 8'h02);

    // Continuous valid: drops saturate, capture is isolated, back-to-back accept
    busy_len = 20;
    q.delete();
    @(negedge clk);
    sample_data  = {16'h3333, 16'h2222, 16'h1111};
    sample_valid = 1'b1;
    n = 0;
    while (!sample_ready && n < 1000) begin @(negedge clk); n++; end
    @(negedge clk);
    sample_data = {16'h0000, 16'h0000, 16'h00F0};
    seen_done = 1'b0; ready_at_done = 1'b0; restarted = 1'b0; done_at = -10;
    for (int i = 0; i < 299; i++) begin
      @(negedge clk);
      if (i == done_at + 1) restarted = pkt_busy;
      if (!pkt_busy && !seen_done) begin
        seen_done     = 1'b1;
        ready_at_done = sample_ready;
        done_at       = i;
        pkt1          = q;
        q.delete();
      end
    end
    check("t3_done_seen", seen_done, 1);
    check("t3_ready_at_done", ready_at_done, 1);
    check("t3_restart", restarted, 1);
    check("t3_drop_sat", drop_cnt, 8'hFF);
    sample_valid = 1'b0;
    @(negedge clk);
    check("t3_drop_hold", drop_cnt, 8'hFF);
    wait_done(5000);
    check_pkt("t3a", pkt1, '{8'hA5, 8'h5A, 8'h03, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'hCF});
    check_pkt("t3b", q, '{8'hA5, 8'h5A, 8'h04, 8'h00, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF4});

    // Reset mid-packet
    busy_len = 3;
    s0 = starts;
    send_sample({16'hC0DE, 16'hBEEF, 16'h1234});
    n = 0;
    while ((starts - s0 < 5) && n < 2000) begin @(negedge clk); n++; end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_ready", sample_ready, 0);
    check("t5_start", tx_start, 0);
    check("t5_data", tx_data, 8'h00);
    check("t5_pkt_busy", pkt_busy, 0);
    check("t5_seq", seq, 0);
    check("t5_drop", drop_cnt, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (tx_busy && n < 100) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    q.delete();
    send_sample({16'h0506, 16'h0304, 16'h0102});
    wait_done(5000);
    check_pkt("t5", q, '{8'hA5, 8'h5A, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h15});

    // Sequence wrap over 257 zero packets
    do_reset();
    busy_len = 1;
    for (int k = 1; k <= 257; k++) begin
      q.delete();
      send_sample('0);
      wait_done(2000);
      if (k == 256) begin
        check_pkt("t4_p256", q, '{8'hA5, 8'h5A, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF});
        check("t4_seq_wrap", seq, 8'h00);
      end
      if (k == 257) begin
        check("t4_p257_seq", q[2], 8'h00);
        check("t4_seq_after", seq, 8'h01);
      end
    end

    // Single-channel instance
    q1.delete();
    @(negedge clk);
    sample_data1  = 16'h8001;
    sample_valid1 = 1'b1;
    n = 0;
    while (!sample_ready1 && n < 1000) begin @(negedge clk); n++; end
    @(negedge clk);
    sample_valid1 = 1'b0;
    n = 0;
    while (pkt_busy1 && n < 2000) begin @(negedge clk); n++; end
    check("t6_done", pkt_busy1, 0);
    check_pkt("t6", q1, '{8'hA5, 8'h5A, 8'h00, 8'h80, 8'h01, 8'h81});
    check("t6_seq", seq1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imu_uart_packetizer.md
Name: imu_uart_packetizer

Overview:
Upstream feeder for the UART transmitter. It accepts one multi-channel IMU sample through a valid/ready handshake and frames it as a fixed-length byte packet: sync bytes, sequence number, channel data and checksum. It then issues the packet one byte at a time over the transmitter's tx_start/tx_data/tx_busy interface. The serial output stays in step with the transmitter's pacing, and samples that arrive while a packet is in flight are counted as drops.

Parameters:
NUM_CH, 3, number of 16-bit channels per sample; legal range 1..8.
SYNC0, 8'hA5, first header byte.
SYNC1, 8'h5A, second header byte.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
sample_valid  in  1  upstream sample available.
sample_data  in  16*NUM_CH  channel k occupies bits [16k+15:16k].
sample_ready  out  1  high when a sample can be accepted.
tx_start  out  1  one-cycle pulse that requests transmission of tx_data.
tx_data  out  8  byte to transmit; held stable from the tx_start pulse until the next byte is loaded.
tx_busy  in  1  transmitter busy; it rises the cycle after the accepted tx_start and falls after the stop bit.
pkt_busy  out  1  high from sample acceptance until the last byte's tx_busy falls.
seq  out  8  sequence number of the next packet.
drop_cnt  out  8  saturating count of samples rejected while busy.

Behaviour:
- Reset values (asynchronous assertion, all outputs registered):
  - sample_ready=0 during reset, then 1 in IDLE.
  - tx_start=0, tx_data=8'h00, pkt_busy=0, seq=0, drop_cnt=0.
  - State returns to IDLE and any packet in progress is abandoned with no partial resume.
- Packet format: PKT_LEN = 4 + 2*NUM_CH bytes (default 10), sent in this order:
  - SYNC0, SYNC1, seq.
  - Channel 0 MSB, channel 0 LSB, through channel NUM_CH-1 MSB, LSB.
  - CHK.
- CHK is the 8-bit sum, modulo 256, of seq and all data bytes. The sync bytes are excluded. Carries are discarded.
- Sample capture:
  - A handshake occurs when sample_valid=1 and sample_ready=1 on the same clk edge.
  - sample_data is registered in full on the handshake edge. Later changes on the input have no effect on the packet.
  - sample_ready=1 only in IDLE. It drops the cycle after the handshake.
- Drops:
  - drop_cnt increments on every cycle with sample_valid=1 and sample_ready=0 while not in reset.
  - drop_cnt saturates at 255.
- State machine:
  - IDLE: sample_ready=1. On handshake: capture the sample, set byte index to 0, set pkt_busy=1, go to LOAD.
  - LOAD: wait until tx_busy=0. Then drive tx_data with byte[index], pulse tx_start=1 for exactly one cycle, add the byte to the running checksum if index is in 2..PKT_LEN-2, go to WAIT_HI.
  - WAIT_HI: wait for tx_busy=1, then go to WAIT_LO. No timeout.
  - WAIT_LO: wait for tx_busy=0.
    - If index < PKT_LEN-1: increment index, go to LOAD.
    - Else: seq increments (wraps 255 to 0), pkt_busy=0, go to IDLE.
- Latency:
  - The first tx_start is asserted the cycle after the handshake, provided tx_busy=0.
  - There is a 1-cycle LOAD gap between a byte's tx_busy falling and the next tx_start.
  - tx_start is never asserted while tx_busy=1 or while in WAIT_HI/WAIT_LO.
- Boundary conditions:
  - The checksum register is cleared on every handshake.
  - The seq value carried in a packet is the value at the handshake.
  - If sample_valid is held high continuously, the next sample is accepted on the first IDLE cycle after the packet completes.
  - A tx_busy glitch in LOAD stalls the block and does not cause an error.

Test Plan:
1. Reset, then present sample 0x1234/0xABCD/0x0001 (ch0..ch2) with sample_valid for one cycle. Required:
   - tx bytes A5 5A 00 12 34 AB CD 00 01 BF.
   - Exactly 10 tx_start pulses.
   - seq=1 after completion.
2. Transmitter model with a short busy (3 cycles) and a long busy (868*10 cycles). Required:
   - Each tx_start is exactly one cycle wide and never overlaps tx_busy=1.
   - tx_data is stable throughout each busy window.
3. Hold sample_valid high for 300 cycles while a packet is in flight. Required:
   - drop_cnt saturates at 255.
   - The packet content is unchanged.
   - A new packet starts right after the first packet completes.
4. Send 257 packets of all-zero data. Required:
   - seq wraps 255 to 0.
   - The 256th packet is A5 5A FF 00 00 00 00 00 00 FF.
5. Assert rst_n low during byte 5 of a packet. Required:
   - Outputs are immediately at reset values.
   - After release, a new sample produces a clean packet starting with A5 and seq 00.
6. Run with NUM_CH=1 on sample 0x8001. Required:
   - PKT_LEN=6.
   - tx bytes A5 5A 00 80 01 81.
